// File: rtl/multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq
//
// Sequential multi-byte adder/subtractor built around one external 8-bit
// combinational adder. Operand byte pairs are loaded least significant byte
// first. They are then summed one byte per cycle through the external adder,
// with the carry rippling through a register. The result is streamed out
// least significant byte first.
//
// Build option:
//   MULTIBYTE_ADD_SEQ_SUB_EN  defined   -> op_sub on the first accepted beat
//                                          selects A - B (A + ~B + 1)
//                             undefined -> op_sub is ignored; the block only
//                                          adds
//
// Parameters:
//   NBYTES     operand width in bytes (1..4)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand byte pair present
//   in_ready   block accepts an operand byte pair (LOAD only)
//   in_a       operand A byte, LSB first
//   in_b       operand B byte, LSB first
//   op_sub     subtract request, sampled on the first beat of an operation
//   add_a      operand byte to the external adder (0 outside ADD)
//   add_b      operand byte to the external adder (0 outside ADD)
//   add_cin    carry-in to the external adder (0 outside ADD)
//   add_sum    external adder sum, same cycle as the drive
//   add_cout   external adder carry-out, same cycle as the drive
//   out_valid  result byte present
//   out_ready  consumer accepts the result byte
//   out_data   result byte, LSB first
//   out_last   final result byte
//   out_carry  final carry, non-zero only together with out_last
// ---------------------------------------------------------------------------
module multibyte_add_seq #(
    parameter int NBYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       op_sub,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_carry
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       a_byte [NBYTES];
    logic [7:0]       b_byte [NBYTES];
    logic [7:0]       r_byte [NBYTES];
    logic             carry;
    logic             sub;
    // Cleared by reset and set on the first clock afterwards, so in_ready
    // stays low while reset is held and rises one clock after release.
    logic             live;

    logic in_fire;
    logic out_fire;
    logic idx_last;

    assign idx_last = (idx == IDX_LAST);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            idx   <= '0;
            carry <= 1'b0;
            live  <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                a_byte[i] <= '0;
                b_byte[i] <= '0;
                r_byte[i] <= '0;
            end
        end else begin
            live <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        a_byte[idx] <= in_a;
                        b_byte[idx] <= in_b;
                        if (idx_last) begin
                            state <= ST_ADD;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_ADD: begin
                    r_byte[idx] <= add_sum;
                    carry       <= add_cout;
                    if (idx_last) begin
                        state <= ST_OUT;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        if (idx_last) begin
                            state <= ST_LOAD;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    idx   <= '0;
                end
            endcase
        end
    end

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    // The operation type is latched only on the first beat so a changing
    // op_sub on later beats cannot mix add and subtract within one operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub <= 1'b0;
        end else if (in_fire && (idx == '0)) begin
            sub <= op_sub;
        end
    end
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the carry-in
    // of the least significant byte.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == ST_ADD) begin
            add_a   = a_byte[idx];
            add_b   = sub ? ~b_byte[idx] : b_byte[idx];
            add_cin = (idx == '0) ? sub : carry;
        end
    end

    assign in_ready  = live && (state == ST_LOAD);
    assign out_valid = (state == ST_OUT);
    assign out_data  = out_valid ? r_byte[idx] : 8'h00;
    assign out_last  = out_valid && idx_last;
    assign out_carry = out_last && carry;

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 2, operand width in bytes (legal 1..4).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand byte pair present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand byte pair.
REQ-006 SHALL have port in_a  input  8  operand A byte, least significant byte first.
REQ-007 SHALL have port in_b  input  8  operand B byte, least significant byte first.
REQ-008 SHALL have port op_sub  input  1  subtract request, sampled on first accepted beat only.
REQ-009 SHALL have ports add_a, add_b  output  8 each  operand bytes driven to the external 8-bit combinational adder.
REQ-010 SHALL have port add_cin  output  1  carry-in driven to the adder.
REQ-011 SHALL have ports add_sum  input  8, add_cout  input  1  adder result, valid in the same cycle as the drive.
REQ-012 SHALL have port out_valid  output  1  result byte present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result byte.
REQ-014 SHALL have port out_data  output  8  result byte, LSB first.
REQ-015 SHALL have ports out_last  output  1  final result byte; out_carry  output  1  final carry, meaningful only when out_last=1.

Function
REQ-016 SHALL implement states LOAD, ADD, OUT with a byte index counter idx (0..NBYTES-1).
REQ-017 LOAD: in_ready=1; each in_valid&in_ready stores in_a/in_b into byte slot idx; idx increments; after beat NBYTES-1 -> ADD with idx=0.
REQ-018 ADD: one byte per cycle; add_a=A[idx], add_b=B[idx] (or ~B[idx] when subtracting), add_cin = sub flag when idx=0 else registered carry; add_sum captured into R[idx], add_cout into carry register; after idx=NBYTES-1 -> OUT with idx=0.
REQ-019 Outside ADD, add_a, add_b, add_cin SHALL be 0.
REQ-020 OUT: out_valid=1, out_data=R[idx], out_last=(idx==NBYTES-1), out_carry=final carry when out_last else 0; idx advances only on out_valid&out_ready; accepting the last byte -> LOAD with idx=0.
REQ-021 Latency: last input beat accepted in cycle t -> ADD cycles t+1..t+NBYTES -> out_valid first high in cycle t+NBYTES+1.
REQ-022 in_ready SHALL be 0 in ADD and OUT; in_valid there SHALL be ignored.
REQ-023 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Result SHALL be (A + B) mod 2^(8*NBYTES), or (A + ~B + 1) when subtracting; carry wraps, no overflow flag.

Reset
REQ-025 rst_n low SHALL immediately force state LOAD, idx=0, carry=0, sub flag=0, A/B/R cleared.
REQ-026 During reset: in_ready=0, out_valid=0, out_data=0, out_last=0, out_carry=0, add_a=add_b=0, add_cin=0; in_ready rises first clock after rst_n deasserts.
REQ-027 Reset mid-LOAD, mid-ADD or mid-OUT SHALL abandon the operation; no partial result emitted afterwards.

Configuration
REQ-028 Macro MULTIBYTE_ADD_SEQ_SUB_EN: defined -> op_sub honoured per REQ-018/024; undefined -> op_sub ignored, sub flag constant 0, block adds only.

Verification
REQ-029 NBYTES=2, A=0x12FF, B=0x0001, add -> out bytes 0x00 then 0x13, out_last on second, out_carry=0.
REQ-030 A=0xFFFF, B=0x0001 -> out bytes 0x00, 0x00, out_carry=1; out_valid exactly 3 cycles after last input beat.
REQ-031 SUB_EN defined, op_sub=1, A=0x1000, B=0x0001 -> 0xFF, 0x0F, out_carry=1; with macro undefined same stimulus -> 0x01, 0x10, carry 0.
REQ-032 out_ready held 0 for 5 cycles in OUT -> out_data/out_last stable, in_ready stays 0; release -> bytes drain in order.
REQ-033 rst_n pulsed low during ADD idx=1 -> all outputs 0 immediately, in_ready=1 after release, no out_valid until a new operation completes.
REQ-034 in_valid gaps between beats (1 idle cycle) and back-to-back operations -> results identical to gap-free case, no beat dropped.
